frame_read_scheduler: RTL and testbench
=======================================

// Module: frame_read_scheduler
// PURPOSE
//  Sequences DDR frame-buffer reads that feed the pixel FIFO in front of Video_timing_generator.
//  - On each vsync_start_pulse: flushes the FIFO, then issues fixed-length burst requests to the AXI4 reader.
//  - Requests walk one full frame of QVGA RGB565 (320x240x2 B) from the active read buffer.
//  - Arbitrates a double buffer between the PL writer and this reader: read buffer swaps only at a frame boundary.
// PARAMETERS
//  FRAME_BASE0   32'h1000_0000  byte address of buffer 0
//  FRAME_BASE1   32'h1010_0000  byte address of buffer 1
//  H_PIXELS      320            pixels per source line
//  V_LINES       240            source lines per frame
//  BEAT_BYTES    8              bytes per AXI data beat (64-bit bus)
//  BURST_BEATS   16             beats per burst request; H_PIXELS*V_LINES*2 divisible by BEAT_BYTES*BURST_BEATS
//  FIFO_AW       10             FIFO depth 2**FIFO_AW beats; width of fifo_free is FIFO_AW+1
//  FLUSH_CYCLES  4              cycles fifo_flush is held high
// PORTS
//  clk                input   1         pixel/AXI-read clock
//  rst                input   1         asynchronous, active-high reset
//  enable             input   1         level; 0 parks the block in IDLE at the next frame boundary
//  vsync_start_pulse  input   1         1-cycle pulse from VTG (v_count==490, h_count==0)
//  wr_frame_done      input   1         1-cycle pulse: writer finished a frame into wr_buf_sel
//  fifo_free          input   FIFO_AW+1 free beats in pixel FIFO
//  fifo_flush         output  1         synchronous FIFO clear
//  req_valid          output  1         burst request valid
//  req_ready          input   1         AXI reader accepts request
//  req_addr           output  32        burst start byte address
//  req_len            output  8         AXI ARLEN = BURST_BEATS-1 (constant)
//  burst_done         input   1         1-cycle pulse: reader finished the accepted burst
//  rd_buf_sel         output  1         buffer being read (0/1)
//  wr_buf_sel         output  1         buffer writer may fill = ~rd_buf_sel
//  frame_late         output  1         1-cycle pulse: vsync arrived before frame fully requested/completed
//  busy               output  1         high in any state except IDLE
// BEHAVIOUR
//  - Reset: fifo_flush=0, req_valid=0, req_addr=0, rd_buf_sel=0, frame_late=0, busy=0; state IDLE; swap_pend=0; burst_cnt=0.
//  - NBURST = H_PIXELS*V_LINES*2/(BEAT_BYTES*BURST_BEATS) (1200 at defaults). burst_cnt is 0..NBURST-1.
//  - Address: req_addr = base(rd_buf_sel) + burst_cnt*BEAT_BYTES*BURST_BEATS, computed in 32 bits; overflow not checked.
//  - States:
//    - IDLE: vsync_start_pulse && enable -> FLUSH.
//    - FLUSH: fifo_flush=1 for FLUSH_CYCLES cycles; burst_cnt<=0; then -> WAIT_SPACE.
//    - WAIT_SPACE: fifo_free >= BURST_BEATS -> ISSUE (req_valid rises next cycle).
//    - ISSUE: req_valid=1; req_addr/req_len stable until req_valid&&req_ready; then -> WAIT_DONE.
//    - WAIT_DONE: on burst_done:
//      - burst_cnt==NBURST-1 -> DONE.
//      - else burst_cnt++, -> WAIT_SPACE.
//    - DONE: wait for vsync_start_pulse; -> FLUSH if enable, else IDLE.
//  - Latency: vsync pulse at cycle t -> fifo_flush high t+1..t+FLUSH_CYCLES; earliest req_valid at t+FLUSH_CYCLES+2.
//  - Max one outstanding burst. req_valid never drops without handshake, even if rst-less abort requested.
//  - Buffer swap:
//    - wr_frame_done sets swap_pend.
//    - On a vsync_start_pulse that starts a frame: if swap_pend, rd_buf_sel toggles and swap_pend clears, same edge.
//    - Both pulses in the same cycle: the swap happens at that vsync.
//    - wr_frame_done while swap_pend=1: no effect (latest frame stays pending).
//  - Late vsync (state WAIT_SPACE/ISSUE/WAIT_DONE):
//    - frame_late pulses 1 cycle at t+1; restart_pend set.
//    - WAIT_SPACE: go to FLUSH directly.
//    - ISSUE: complete handshake, wait for burst_done, then FLUSH.
//    - WAIT_DONE: wait for burst_done, then FLUSH.
//    - Swap evaluated at the vsync edge as normal.
//  - vsync during FLUSH: ignored apart from frame_late pulse; the flush count is not restarted.
//  - enable=0 mid-frame: current frame completes; next vsync -> IDLE, no flush.
//  - Async rst mid-burst: all outputs to reset values immediately; the AXI reader is reset by the same rst.
// TESTING (use H_PIXELS=8, V_LINES=2, BEAT_BYTES=8, BURST_BEATS=2 -> NBURST=2, 16 B/burst; FLUSH_CYCLES=4)
//  1. enable=1, fifo_free=16, req_ready=1, vsync at t=10 -> fifo_flush t11..14; req_addr 0x1000_0000 then 0x1000_0010; DONE after 2nd burst_done.
//  2. Wait-state: fifo_free=1 for 20 cycles then 16 -> req_valid stays 0 until fifo_free>=2, then rises next cycle.
//  3. req_ready low 5 cycles -> req_valid and req_addr held constant, single handshake counted.
//  4. wr_frame_done then vsync -> rd_buf_sel=1, wr_buf_sel=0, first req_addr 0x1010_0000; simultaneous pulses -> same result.
//  5. vsync while WAIT_DONE (burst 0) -> frame_late one pulse; burst_done -> flush -> restart at burst 0.
//  6. rst asserted during ISSUE -> req_valid=0, busy=0 asynchronously; after release, idle until next vsync.

Source files
------------

// File: rtl/frame_read_scheduler.sv
// Sequences fixed-length DDR burst reads for one frame per vsync into the pixel FIFO,
// and owns the read/write double-buffer selection shared with the PL frame writer.
module frame_read_scheduler #(
  parameter logic [31:0] FRAME_BASE0  = 32'h1000_0000,
  parameter logic [31:0] FRAME_BASE1  = 32'h1010_0000,
  parameter int          H_PIXELS     = 320,
  parameter int          V_LINES      = 240,
  parameter int          BEAT_BYTES   = 8,
  parameter int          BURST_BEATS  = 16,
  parameter int          FIFO_AW      = 10,
  parameter int          FLUSH_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             vsync_start_pulse,
  input  logic             wr_frame_done,
  input  logic [FIFO_AW:0] fifo_free,
  output logic             fifo_flush,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [31:0]      req_addr,
  output logic [7:0]       req_len,
  input  logic             burst_done,
  output logic             rd_buf_sel,
  output logic             wr_buf_sel,
  output logic             frame_late,
  output logic             busy
);

  localparam int NBURST = H_PIXELS * V_LINES * 2 / (BEAT_BYTES * BURST_BEATS);
  localparam int CW     = (NBURST > 1) ? $clog2(NBURST) : 1;
  localparam int FW     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [31:0]      BURST_BYTES = 32'(BEAT_BYTES * BURST_BEATS);
  localparam logic [CW-1:0]    LAST_BURST  = CW'(NBURST - 1);
  localparam logic [FW-1:0]    FLUSH_LAST  = FW'(FLUSH_CYCLES - 1);
  localparam logic [FIFO_AW:0] NEED_FREE   = (FIFO_AW+1)'(BURST_BEATS);

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_WAIT_SPACE, S_ISSUE, S_WAIT_DONE, S_DONE
  } state_t;

  state_t        state_q;
  logic [CW-1:0] burst_cnt_q;
  logic [FW-1:0] flush_cnt_q;
  logic          swap_pend_q, restart_pend_q;
  logic          fifo_flush_q, req_valid_q, rd_buf_sel_q, frame_late_q, busy_q;
  logic [31:0]   req_addr_q;

  logic        vs_late, vs_in_flush, swap_evt, pend_now;
  logic [31:0] next_addr;

  assign vs_late     = vsync_start_pulse &&
                       (state_q == S_WAIT_SPACE || state_q == S_ISSUE || state_q == S_WAIT_DONE);
  assign vs_in_flush = vsync_start_pulse && (state_q == S_FLUSH);
  // A frame starts on any late vsync, or on an on-time vsync while enabled.
  assign swap_evt    = vs_late ||
                       (vsync_start_pulse && enable && (state_q == S_IDLE || state_q == S_DONE));
  assign pend_now    = swap_pend_q | wr_frame_done;
  assign next_addr   = (rd_buf_sel_q ? FRAME_BASE1 : FRAME_BASE0) + 32'(burst_cnt_q) * BURST_BYTES;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      burst_cnt_q    <= '0;
      flush_cnt_q    <= '0;
      swap_pend_q    <= 1'b0;
      restart_pend_q <= 1'b0;
      fifo_flush_q   <= 1'b0;
      req_valid_q    <= 1'b0;
      req_addr_q     <= '0;
      rd_buf_sel_q   <= 1'b0;
      frame_late_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      frame_late_q <= vs_late || vs_in_flush;

      // A done pulse coinciding with the swapping vsync is consumed by that swap.
      if (swap_evt && pend_now) begin
        rd_buf_sel_q <= ~rd_buf_sel_q;
        swap_pend_q  <= 1'b0;
      end else if (wr_frame_done) begin
        swap_pend_q  <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (vsync_start_pulse && enable) begin
            state_q      <= S_FLUSH;
            fifo_flush_q <= 1'b1;
            flush_cnt_q  <= '0;
            busy_q       <= 1'b1;
          end
        end
        S_FLUSH: begin
          burst_cnt_q <= '0;
          if (flush_cnt_q == FLUSH_LAST) begin
            fifo_flush_q <= 1'b0;
            state_q      <= S_WAIT_SPACE;
          end else begin
            flush_cnt_q  <= flush_cnt_q + 1'b1;
          end
        end
        S_WAIT_SPACE: begin
          if (vsync_start_pulse) begin
            // Nothing outstanding, so a late vsync restarts immediately.
            if (enable) begin
              state_q      <= S_FLUSH;
              fifo_flush_q <= 1'b1;
              flush_cnt_q  <= '0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else if (fifo_free >= NEED_FREE) begin
            state_q     <= S_ISSUE;
            req_valid_q <= 1'b1;
            req_addr_q  <= next_addr;
          end
        end
        S_ISSUE: begin
          if (vsync_start_pulse) restart_pend_q <= 1'b1;
          if (req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (burst_done) begin
            if (restart_pend_q || vsync_start_pulse) begin
              restart_pend_q <= 1'b0;
              if (enable) begin
                state_q      <= S_FLUSH;
                fifo_flush_q <= 1'b1;
                flush_cnt_q  <= '0;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end else if (burst_cnt_q == LAST_BURST) begin
              state_q <= S_DONE;
            end else begin
              burst_cnt_q <= burst_cnt_q + 1'b1;
              state_q     <= S_WAIT_SPACE;
            end
          end else if (vsync_start_pulse) begin
            restart_pend_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (vsync_start_pulse) begin
            if (enable) begin
              state_q      <= S_FLUSH;
              fifo_flush_q <= 1'b1;
              flush_cnt_q  <= '0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fifo_flush = fifo_flush_q;
  assign req_valid  = req_valid_q;
  assign req_addr   = req_addr_q;
  assign req_len    = 8'(BURST_BEATS - 1);
  assign rd_buf_sel = rd_buf_sel_q;
  assign wr_buf_sel = ~rd_buf_sel_q;
  assign frame_late = frame_late_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_frame_read_scheduler.sv
// Scoreboard bench for frame_read_scheduler on a tiny 2-burst frame (16 B per burst).
module tb_frame_read_scheduler;
  localparam int FIFO_AW = 10;

  logic             clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic             vsync = 1'b0, wfd = 1'b0, req_ready = 1'b0, burst_done = 1'b0;
  logic [FIFO_AW:0] fifo_free = 11'd16;
  logic             fifo_flush, req_valid, rd_buf_sel, wr_buf_sel, frame_late, busy;
  logic [31:0]      req_addr;
  logic [7:0]       req_len;

  int          n_checks = 0, n_fail = 0, hs_cnt = 0, done_cnt = 0, done_dly = 4;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  frame_read_scheduler #(
    .H_PIXELS(8), .V_LINES(2), .BEAT_BYTES(8), .BURST_BEATS(2),
    .FIFO_AW(FIFO_AW), .FLUSH_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .vsync_start_pulse(vsync),
    .wr_frame_done(wfd), .fifo_free(fifo_free), .fifo_flush(fifo_flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len(req_len), .burst_done(burst_done), .rd_buf_sel(rd_buf_sel),
    .wr_buf_sel(wr_buf_sel), .frame_late(frame_late), .busy(busy)
  );

  // Handshake scoreboard: every accepted request must match the next expected address.
  always @(negedge clk) begin
    if (!rst && req_valid && req_ready) begin
      hs_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_addr: unexpected request addr=%h, required no request", req_addr);
      end else begin
        mon_exp = exp_q.pop_front();
        if (req_addr !== mon_exp || req_len !== 8'd1) begin
          n_fail++;
          $display("FAIL sb_addr: got addr=%h len=%0d, required addr=%h len=1", req_addr, req_len, mon_exp);
        end
      end
    end
  end

  // AXI reader model: burst_done done_dly cycles after each accepted request.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && req_valid && req_ready) begin
        @(posedge clk);
        repeat (done_dly - 1) @(posedge clk);
        #1 burst_done = 1'b1;
        done_cnt++;
        @(posedge clk);
        #1 burst_done = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_vsync();
    tick(); vsync = 1'b1;
    tick(); vsync = 1'b0;
  endtask

  task automatic wait_dones(input int n, input string name);
    int target = done_cnt + n;
    int k = 0;
    while (done_cnt < target && k < 500) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (done_cnt < target) begin
      n_fail++;
      $display("FAIL %s: timeout, got %0d burst_done, required %0d", name, done_cnt, target);
    end
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!req_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (!req_valid) begin
      n_fail++;
      $display("FAIL %s: timeout, req_valid=%b required 1", name, req_valid);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({fifo_flush, req_valid, req_addr, rd_buf_sel, wr_buf_sel, frame_late, busy, req_len}
        !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL reset: flush=%b valid=%b addr=%h rd=%b wr=%b late=%b busy=%b len=%0d, required 0 0 0 0 1 0 0 1",
               fifo_flush, req_valid, req_addr, rd_buf_sel, wr_buf_sel, frame_late, busy, req_len);
    end
    tick();
    rst = 1'b0; enable = 1'b1; req_ready = 1'b1;
  endtask

  task automatic test_first_frame();
    int ff = 0, fcnt = 0, rv = 0;
    exp_q.push_back(32'h1000_0000);
    exp_q.push_back(32'h1000_0010);
    pulse_vsync();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (fifo_flush) begin
        fcnt++;
        if (ff == 0) ff = k;
      end
      if (req_valid && rv == 0) rv = k;
    end
    n_checks++;
    if (ff != 1 || fcnt != 4) begin
      n_fail++;
      $display("FAIL flush_window: first=%0d cycles=%0d, required first=1 cycles=4", ff, fcnt);
    end
    n_checks++;
    if (rv != 6) begin
      n_fail++;
      $display("FAIL req_latency: req_valid at cycle %0d, required 6", rv);
    end
    wait_dones(2, "first_frame");
    repeat (10) @(negedge clk);
    n_checks++;
    if (req_valid !== 1'b0 || busy !== 1'b1 || hs_cnt != 2 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL frame_done: valid=%b busy=%b handshakes=%0d pending=%0d, required 0 1 2 0",
               req_valid, busy, hs_cnt, exp_q.size());
    end
  endtask

  task automatic test_wait_space();
    int bad = 0;
    logic v0, v1;
    tick(); fifo_free = 11'd1;
    exp_q.push_back(32'h1000_0000);
    exp_q.push_back(32'h1000_0010);
    pulse_vsync();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_valid) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL wait_space: req_valid high %0d cycles with fifo_free=1, required 0", bad);
    end
    tick(); fifo_free = 11'd16;
    @(negedge clk); v0 = req_valid;
    @(negedge clk); v1 = req_valid;
    n_checks++;
    if (v0 !== 1'b0 || v1 !== 1'b1) begin
      n_fail++;
      $display("FAIL space_rise: valid=%b then %b, required 0 then 1", v0, v1);
    end
    wait_dones(2, "wait_space");
  endtask

  task automatic test_ready_stall();
    logic [31:0] a0;
    int h0, held = 0;
    tick(); req_ready = 1'b0;
    exp_q.push_back(32'h1000_0000);
    exp_q.push_back(32'h1000_0010);
    pulse_vsync();
    wait_valid("stall_valid");
    a0 = req_addr;
    h0 = hs_cnt;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (req_valid !== 1'b1 || req_addr !== a0) held++;
    end
    n_checks++;
    if (held != 0 || a0 !== 32'h1000_0000) begin
      n_fail++;
      $display("FAIL stall_hold: %0d unstable cycles addr=%h, required 0 and 10000000", held, a0);
    end
    tick(); req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (req_valid !== 1'b0 || hs_cnt != h0 + 1) begin
      n_fail++;
      $display("FAIL stall_handshake: valid=%b handshakes=%0d, required 0 and %0d", req_valid, hs_cnt, h0 + 1);
    end
    wait_dones(2, "ready_stall");
  endtask

  task automatic test_swap();
    tick(); wfd = 1'b1;
    tick(); wfd = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rd_buf_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL swap_pending: rd_buf_sel=%b before vsync, required 0", rd_buf_sel);
    end
    exp_q.push_back(32'h1010_0000);
    exp_q.push_back(32'h1010_0010);
    pulse_vsync();
    @(negedge clk);
    n_checks++;
    if (rd_buf_sel !== 1'b1 || wr_buf_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL swap_vsync: rd=%b wr=%b, required rd=1 wr=0", rd_buf_sel, wr_buf_sel);
    end
    wait_dones(2, "swap_frame");
    exp_q.push_back(32'h1000_0000);
    exp_q.push_back(32'h1000_0010);
    tick(); vsync = 1'b1; wfd = 1'b1;
    tick(); vsync = 1'b0; wfd = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rd_buf_sel !== 1'b0 || wr_buf_sel !== 1'b1) begin
      n_fail++;
      $display("FAIL swap_same_cycle: rd=%b wr=%b, required rd=0 wr=1", rd_buf_sel, wr_buf_sel);
    end
    wait_dones(2, "swap_same_frame");
  endtask

  task automatic test_late_vsync();
    int h0, d0, lates = 0, fl = 0, k = 0;
    done_dly = 12;
    tick();
    exp_q.push_back(32'h1000_0000);
    h0 = hs_cnt;
    pulse_vsync();
    while (hs_cnt == h0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    exp_q.push_back(32'h1000_0000);
    exp_q.push_back(32'h1000_0010);
    pulse_vsync();
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (frame_late) lates++;
      if (fifo_flush) fl++;
    end
    n_checks++;
    if (lates != 1 || fl != 0) begin
      n_fail++;
      $display("FAIL late_pulse: frame_late cycles=%0d flush cycles=%0d, required 1 and 0", lates, fl);
    end
    d0 = done_cnt;
    k = 0;
    while (done_cnt == d0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    done_dly = 4;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (fifo_flush !== 1'b1) begin
      n_fail++;
      $display("FAIL late_flush: fifo_flush=%b after burst_done, required 1", fifo_flush);
    end
    wait_dones(2, "late_restart");
  endtask

  task automatic test_disable();
    int act = 0;
    tick();
    exp_q.push_back(32'h1000_0000);
    exp_q.push_back(32'h1000_0010);
    pulse_vsync();
    tick(); enable = 1'b0;
    wait_dones(2, "disable_frame");
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL disable_complete: busy=%b at frame end, required 1", busy);
    end
    pulse_vsync();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (fifo_flush || busy) act++;
    end
    n_checks++;
    if (act != 0) begin
      n_fail++;
      $display("FAIL disable_idle: %0d active cycles after vsync, required 0", act);
    end
    tick(); enable = 1'b1;
  endtask

  task automatic test_async_reset();
    int act = 0;
    tick(); req_ready = 1'b0; wfd = 1'b1;
    tick(); wfd = 1'b0;
    pulse_vsync();
    wait_valid("rst_valid");
    n_checks++;
    if (req_addr !== 32'h1010_0000 || rd_buf_sel !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_swap: addr=%h rd=%b, required 10100000 and 1", req_addr, rd_buf_sel);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({req_valid, busy, fifo_flush, rd_buf_sel, req_addr} !== 36'h0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b busy=%b flush=%b rd=%b addr=%h, required all 0",
               req_valid, busy, fifo_flush, rd_buf_sel, req_addr);
    end
    tick(); tick();
    rst = 1'b0; req_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy || req_valid || fifo_flush) act++;
    end
    n_checks++;
    if (act != 0) begin
      n_fail++;
      $display("FAIL post_reset_idle: %0d active cycles, required 0", act);
    end
    exp_q.push_back(32'h1000_0000);
    exp_q.push_back(32'h1000_0010);
    pulse_vsync();
    wait_dones(2, "post_reset_frame");
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_wait_space();
    test_ready_stall();
    test_swap();
    test_late_vsync();
    test_disable();
    test_async_reset();
    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expected requests never issued, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
